// File: rtl/core_array_pkg.sv
// Shared opcode field positions, mask-update encodings and serializer state for core_array_ctrl.
package core_array_pkg;

    localparam logic [1:0] OP_CLASS_MISC = 2'b11;
    localparam int OP_CLASS_HI   = 15;
    localparam int OP_CLASS_LO   = 14;
    localparam int OP_GIDX_HI    = 12;
    localparam int OP_GIDX_LO    = 9;
    localparam int OP_SEL_LO     = 9;
    localparam int OP_STORE_BIT  = 7;
    localparam int OP_MASK_HI    = 6;
    localparam int OP_MASK_LO    = 5;
    localparam int OP_OUT_BIT    = 4;
    localparam int OP_REDUCE_BIT = 3;

    typedef enum logic [1:0] {
        MASK_NOP  = 2'b00,
        MASK_SEL  = 2'b01,
        MASK_ALL  = 2'b10,
        MASK_NONE = 2'b11
    } mask_op_e;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/core_array_ctrl_out_serializer.sv
// Multi-beat LSB-first word serializer with valid/ready handshake and drop pulse on busy loads.
//  state    | meaning
//  SER_IDLE | no word in flight, a load starts a new word
//  SER_SEND | beats being presented, loads only accepted on the final handshake
module out_serializer
    import core_array_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [BIT_WIDTH-1:0] i_word,
    input  logic                 i_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_drop
);

    localparam int BEATS = BIT_WIDTH / OUT_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    ser_state_e           r_state;
    logic [BIT_WIDTH-1:0] r_shreg;
    logic [CW-1:0]        r_cnt;
    logic                 r_drop;
    logic                 w_hs;
    logic                 w_final;

    assign w_hs    = (r_state == SER_SEND) & i_ready;
    assign w_final = w_hs & (r_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SER_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                SER_IDLE: begin
                    if (i_load) begin
                        r_state <= SER_SEND;
                        r_shreg <= i_word;
                        r_cnt   <= '0;
                    end
                end
                SER_SEND: begin
                    if (w_final) begin
                        // a load on the final handshake chains the next word with no idle gap
                        if (i_load) begin
                            r_shreg <= i_word;
                        end else begin
                            r_state <= SER_IDLE;
                            r_shreg <= '0;
                        end
                        r_cnt <= '0;
                    end else begin
                        if (w_hs) begin
                            r_shreg <= r_shreg >> OUT_WIDTH;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                        if (i_load) begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                default: r_state <= SER_IDLE;
            endcase
        end
    end

    assign o_valid = (r_state == SER_SEND);
    assign o_last  = (r_state == SER_SEND) & (r_cnt == LAST_CNT);
    assign o_data  = r_shreg[OUT_WIDTH-1:0];
    assign o_drop  = r_drop;

endmodule

// File: rtl/core_array_ctrl.sv
// GPU core-array control: misc-opcode decode, core-enable mask, global registers, output serializer.
// Optional CORE_ARRAY_REDUCE_EN adds a sum-of-enabled-cores store selected by opcode[3].
module core_array_ctrl
    import core_array_pkg::*;
#(
    parameter int NR_CORES   = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int NR_GLOBALS = 16,
    parameter int OUT_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [15:0]                      opcode,
    input  logic                             execute,
    input  logic [NR_CORES*2*BIT_WIDTH-1:0]  accu_in,
    output logic [NR_CORES-1:0]              core_execute,
    output logic [NR_GLOBALS*BIT_WIDTH-1:0]  globals_out,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             out_drop
);

    localparam int CA = (NR_CORES > 1) ? $clog2(NR_CORES) : 1;
    localparam int AW = 2 * BIT_WIDTH;

    logic [NR_CORES-1:0]  r_mask;
    logic [BIT_WIDTH-1:0] r_globals [NR_GLOBALS];

    logic                 w_misc;
    logic                 w_store;
    logic                 w_out;
    logic [CA-1:0]        w_sel;
    logic [3:0]           w_gidx;
    mask_op_e             w_mask_op;
    logic [NR_CORES-1:0]  w_onehot;
    logic [BIT_WIDTH-1:0] w_out_word;
    logic [BIT_WIDTH-1:0] w_low_word;
    logic                 w_any;
    logic [BIT_WIDTH-1:0] w_store_word;
    logic                 w_store_en;
    logic                 w_unused;

    assign w_misc    = execute & (opcode[OP_CLASS_HI:OP_CLASS_LO] == OP_CLASS_MISC);
    assign w_store   = w_misc & opcode[OP_STORE_BIT];
    assign w_out     = w_misc & opcode[OP_OUT_BIT];
    assign w_sel     = opcode[CA+OP_SEL_LO-1:OP_SEL_LO];
    assign w_gidx    = opcode[OP_GIDX_HI:OP_GIDX_LO];
    assign w_mask_op = mask_op_e'(opcode[OP_MASK_HI:OP_MASK_LO]);

    assign core_execute = {NR_CORES{execute}} & r_mask;

    // descending scan so the lowest enabled core is the one that sticks
    always_comb begin
        w_low_word = '0;
        w_any      = 1'b0;
        w_onehot   = '0;
        w_out_word = '0;
        w_unused   = ^{opcode[13], opcode[8], opcode[3:0]};
        for (int i = NR_CORES - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_word = accu_in[i*AW +: BIT_WIDTH];
                w_any      = 1'b1;
            end
            if (w_sel == CA'(i)) begin
                w_onehot[i] = 1'b1;
                w_out_word  = accu_in[i*AW +: BIT_WIDTH];
            end
            w_unused = w_unused ^ (^accu_in[i*AW+BIT_WIDTH +: BIT_WIDTH]);
        end
    end

`ifdef CORE_ARRAY_REDUCE_EN
    logic [BIT_WIDTH-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NR_CORES; i++) begin
            if (r_mask[i]) begin
                w_sum = w_sum + accu_in[i*AW +: BIT_WIDTH];
            end
        end
    end

    assign w_store_word = opcode[OP_REDUCE_BIT] ? w_sum : w_low_word;
    assign w_store_en   = w_store & (opcode[OP_REDUCE_BIT] | w_any);
`else
    assign w_store_word = w_low_word;
    assign w_store_en   = w_store & w_any;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (w_misc) begin
            case (w_mask_op)
                MASK_SEL:  r_mask <= w_onehot;
                MASK_ALL:  r_mask <= '1;
                MASK_NONE: r_mask <= '0;
                default:   r_mask <= r_mask;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NR_GLOBALS; g++) begin
                r_globals[g] <= '0;
            end
        end else if (w_store_en) begin
            for (int g = 0; g < NR_GLOBALS; g++) begin
                if (w_gidx == 4'(g)) begin
                    r_globals[g] <= w_store_word;
                end
            end
        end
    end

    for (genvar g = 0; g < NR_GLOBALS; g++) begin : g_glob
        assign globals_out[g*BIT_WIDTH +: BIT_WIDTH] = r_globals[g];
    end

    out_serializer #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_out),
        .i_word  (w_out_word),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (out_valid),
        .o_last  (out_last),
        .o_drop  (out_drop)
    );

endmodule

// File: tb/tb_core_array_ctrl.sv
// Self-checking bench for core_array_ctrl (4 cores, 8-bit words, 16 globals, 2-bit beats).
module tb_core_array_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  opcode;
    logic         execute;
    logic [63:0]  accu_in;
    logic [3:0]   core_execute;
    logic [127:0] globals_out;
    logic [1:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         out_drop;

    int errors = 0;
    int checks = 0;

    core_array_ctrl #(
        .NR_CORES   (4),
        .BIT_WIDTH  (8),
        .NR_GLOBALS (16),
        .OUT_WIDTH  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .execute      (execute),
        .accu_in      (accu_in),
        .core_execute (core_execute),
        .globals_out  (globals_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .out_drop     (out_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op;
        logic        ex;
        logic [7:0]  a0, a1, a2, a3;
        logic [3:0]  cexec;
        int          gidx;
        logic [7:0]  gexp;
    } vec_t;

    vec_t vt[11];

    // reference state for the random phase
    logic [3:0] m_mask;
    logic [7:0] m_g[16];
    int         m_q[$];
    logic       m_drop;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_accu(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
        accu_in = {$urandom, $urandom};
        accu_in[7:0]   = a0;
        accu_in[23:16] = a1;
        accu_in[39:32] = a2;
        accu_in[55:48] = a3;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step;
        logic [7:0] acc[4];
        logic       misc;
        int         qs;
        logic       hs;
        int         k;
        logic [7:0] w;
        for (int i = 0; i < 4; i++) acc[i] = accu_in[i*16 +: 8];
        misc = execute && (opcode[15:14] == 2'b11);
        qs = m_q.size();
        hs = (qs > 0) && out_ready;
        m_drop = 1'b0;
        if (hs) void'(m_q.pop_front());
        if (misc && opcode[4]) begin
            if (qs == 0 || (hs && qs == 1)) begin
                m_q.delete();
                w = acc[opcode[10:9]];
                for (int b = 0; b < 4; b++) m_q.push_back(int'((w >> (2*b)) & 8'h3));
            end else begin
                m_drop = 1'b1;
            end
        end
        if (misc && opcode[7]) begin
            k = -1;
            for (int i = 0; i < 4; i++) if (m_mask[i] && k < 0) k = i;
`ifdef CORE_ARRAY_REDUCE_EN
            if (opcode[3]) begin
                w = 8'h00;
                for (int i = 0; i < 4; i++) if (m_mask[i]) w = w + acc[i];
                m_g[opcode[12:9]] = w;
            end else if (k >= 0) begin
                m_g[opcode[12:9]] = acc[k];
            end
`else
            if (k >= 0) m_g[opcode[12:9]] = acc[k];
`endif
        end
        if (misc) begin
            case (opcode[6:5])
                2'b01: m_mask = 4'b0001 << opcode[10:9];
                2'b10: m_mask = 4'b1111;
                2'b11: m_mask = 4'b0000;
                default: ;
            endcase
        end
    endtask

    initial begin
        int         exp_b[4];
        int         rp[9];
        int         nb;
        logic [1:0] held;
        logic       was_stall;
        logic [127:0] eg;

        vt[0]  = '{16'hC040, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 0, 8'h00};
        vt[1]  = '{16'hC680, 1'b1, 8'h5A, 8'h11, 8'h00, 8'h00, 4'b1111, 3, 8'h5A};
        vt[2]  = '{16'hC420, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111, 3, 8'h5A};
        vt[3]  = '{16'hCA80, 1'b1, 8'h00, 8'h00, 8'h77, 8'h00, 4'b0100, 5, 8'h77};
        vt[4]  = '{16'hCCE0, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h00, 4'b0100, 6, 8'h3C};
        vt[5]  = '{16'hCE80, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 4'b0000, 7, 8'h00};
        vt[6]  = '{16'h4EC0, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 4'b0000, 7, 8'h00};
        vt[7]  = '{16'hC040, 1'b0, 8'h12, 8'h34, 8'h56, 8'h78, 4'b0000, 0, 8'h00};
        vt[8]  = '{16'hC680, 1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0000, 3, 8'h5A};
        vt[9]  = '{16'hC040, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00};
        vt[10] = '{16'hC280, 1'b1, 8'h99, 8'h01, 8'h02, 8'h03, 4'b1111, 1, 8'h99};

        rst_n = 1'b0; execute = 1'b0; opcode = 16'h0000; out_ready = 1'b0; accu_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 128'(out_valid), 128'(1'b0));
        chk("reset_last",  128'(out_last),  128'(1'b0));
        chk("reset_drop",  128'(out_drop),  128'(1'b0));
        chk("reset_data",  128'(out_data),  128'(2'b00));
        chk("reset_globals", globals_out, 128'h0);
        execute = 1'b1;
        #1;
        chk("reset_mask", 128'(core_execute), 128'(4'b1111));
        execute = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // decode, mask and store vectors
        foreach (vt[i]) begin
            opcode = vt[i].op; execute = vt[i].ex; out_ready = 1'b1;
            set_accu(vt[i].a0, vt[i].a1, vt[i].a2, vt[i].a3);
            #1;
            chk($sformatf("vec%0d_cexec", i), 128'(core_execute), 128'(vt[i].cexec));
            tick();
            execute = 1'b0;
            chk($sformatf("vec%0d_global", i), 128'(globals_out[vt[i].gidx*8 +: 8]), 128'(vt[i].gexp));
        end

        // plain word, ready held high: beats 0,1,3,2 for 8'hB4
        chk("idle_valid", 128'(out_valid), 128'(1'b0));
        set_accu(8'h00, 8'hB4, 8'h00, 8'h00);
        opcode = 16'hC210; execute = 1'b1; out_ready = 1'b1;
        tick();
        execute = 1'b0;
        exp_b = '{0, 1, 3, 2};
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("word_valid%0d", b), 128'(out_valid), 128'(1'b1));
            chk($sformatf("word_data%0d", b),  128'(out_data),  128'(exp_b[b]));
            chk($sformatf("word_last%0d", b),  128'(out_last),  128'(b == 3));
            tick();
        end
        chk("word_end_valid", 128'(out_valid), 128'(1'b0));
        chk("word_end_last",  128'(out_last),  128'(1'b0));

        // stalled word with a rejected mid-word command, 8'hC6 -> 2,1,0,3
        rp = '{1, 0, 0, 1, 0, 1, 0, 0, 1};
        exp_b = '{2, 1, 0, 3};
        set_accu(8'h00, 8'hC6, 8'h00, 8'h00);
        opcode = 16'hC210; execute = 1'b1;
        tick();
        execute = 1'b0;
        set_accu(8'h00, 8'h3F, 8'h00, 8'h00);
        nb = 0; was_stall = 1'b0; held = 2'b00;
        for (int i = 0; i < 24 && nb < 4; i++) begin
            out_ready = rp[i % 9][0];
            execute = (i == 2);
            #1;
            chk("stall_valid", 128'(out_valid), 128'(1'b1));
            if (was_stall) chk("stall_hold", 128'(out_data), 128'(held));
            chk("stall_drop", 128'(out_drop), 128'(i == 3));
            chk("stall_last", 128'(out_last), 128'(nb == 3));
            held = out_data;
            was_stall = !out_ready;
            if (out_ready) begin
                chk($sformatf("stall_beat%0d", nb), 128'(out_data), 128'(exp_b[nb]));
                nb++;
            end
            tick();
            execute = 1'b0;
        end
        chk("stall_complete", 128'(nb), 128'(4));
        chk("stall_end_valid", 128'(out_valid), 128'(1'b0));

        // back-to-back: command on the final handshake chains the next word
        out_ready = 1'b1;
        set_accu(8'h00, 8'hB4, 8'hE1, 8'h00);
        opcode = 16'hC210; execute = 1'b1;
        tick();
        execute = 1'b0;
        nb = 0;
        for (int i = 0; i < 8 && !out_last; i++) tick();
        chk("b2b_last_seen", 128'(out_last), 128'(1'b1));
        opcode = 16'hC410; execute = 1'b1;
        tick();
        execute = 1'b0;
        exp_b = '{1, 0, 2, 3};
        chk("b2b_drop", 128'(out_drop), 128'(1'b0));
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("b2b_valid%0d", b), 128'(out_valid), 128'(1'b1));
            chk($sformatf("b2b_data%0d", b),  128'(out_data),  128'(exp_b[b]));
            chk($sformatf("b2b_last%0d", b),  128'(out_last),  128'(b == 3));
            tick();
        end

        // reset mid-word aborts the word and restores mask/globals
        opcode = 16'hC210; execute = 1'b1;
        tick();
        execute = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_last",  128'(out_last),  128'(1'b0));
        chk("arst_data",  128'(out_data),  128'(2'b00));
        chk("arst_globals", globals_out, 128'h0);
        tick();
        chk("arst_valid_hold", 128'(out_valid), 128'(1'b0));
        rst_n = 1'b1;
        tick();
        opcode = 16'h0000; execute = 1'b1;
        #1;
        chk("arst_mask", 128'(core_execute), 128'(4'b1111));
        execute = 1'b0;
        tick();

        // random traffic against the reference model
        m_mask = 4'b1111;
        foreach (m_g[g]) m_g[g] = 8'h00;
        m_q.delete();
        m_drop = 1'b0;
        for (int c = 0; c < 600; c++) begin
            opcode = 16'($urandom);
            if ($urandom_range(0, 3) != 0) opcode[15:14] = 2'b11;
            execute   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            accu_in   = {$urandom, $urandom};
            #1;
            chk("rnd_cexec", 128'(core_execute), 128'(execute ? m_mask : 4'b0000));
            chk("rnd_valid", 128'(out_valid), 128'(m_q.size() > 0));
            if (m_q.size() > 0) chk("rnd_data", 128'(out_data), 128'(m_q[0]));
            chk("rnd_last", 128'(out_last), 128'(m_q.size() == 1));
            chk("rnd_drop", 128'(out_drop), 128'(m_drop));
            eg = '0;
            for (int g = 0; g < 16; g++) eg[g*8 +: 8] = m_g[g];
            chk("rnd_globals", globals_out, eg);
            model_step();
            tick();
        end
        execute = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_array_ctrl.md
# core_array_ctrl

Parametrised control block for the GPU core array. It decodes the misc opcode class, holds the core-enable mask and the global register file, and gates `execute` to each core. It also replaces the single-bit output of the previous generation with a multi-beat serializer that has a valid/ready handshake. Cores sit outside the block: their accumulators come in through a flattened bus, and their gated execute strobes go out the same way.

## Interface
- `NR_CORES`, 4: number of cores; core-id field width `CA = $clog2(NR_CORES)`, minimum 1.
- `BIT_WIDTH`, 8: global register and output word width.
- `NR_GLOBALS`, 16: global register count; must not exceed 16, since the index is `opcode[12:9]`.
- `OUT_WIDTH`, 1: bits per output beat; `BIT_WIDTH % OUT_WIDTH` must be 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  16  instruction word.
- `execute`  in  1  instruction strobe; `opcode` is valid whenever this is high.
- `accu_in`  in  NR_CORES*2*BIT_WIDTH  flattened accumulators; core i occupies slice i.
- `core_execute`  out  NR_CORES  per-core strobe, `execute & mask[i]` (combinational).
- `globals_out`  out  NR_GLOBALS*BIT_WIDTH  flattened global registers; register g occupies slice g.
- `out_data`  out  OUT_WIDTH  current beat.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_last`  out  1  marks the final beat of a word.
- `out_drop`  out  1  one-cycle pulse when an output command is rejected.

## Operation
- An instruction is decoded only when `execute=1` and `opcode[15:14]=2'b11`. All other opcodes change no state here.
- Core-id field is `sel = opcode[CA+8:9]`.
- Global store, `opcode[7]=1`: write `accu_in[k][BIT_WIDTH-1:0]` into `global[opcode[12:9]]`.
  - k is the lowest-index core with `mask[k]=1`.
  - If the mask is zero, no write occurs.
  - If the index is ≥ `NR_GLOBALS`, no write occurs.
- Mask update, `opcode[6:5]`:
  - 01: one-hot `mask = 1<<sel`; if `sel` ≥ `NR_CORES`, mask becomes all-zero.
  - 10: mask becomes all ones.
  - 11: mask becomes all zeros.
  - 00: no change.
- Same-opcode ordering: store uses the mask value held before the edge; the mask update takes effect on the next instruction.
- Output, `opcode[4]=1`:
  - Captures `accu_in[sel][BIT_WIDTH-1:0]` into the shift register; captures 0 if `sel` ≥ `NR_CORES`.
  - The word is sent LSB-first as `BEATS = BIT_WIDTH/OUT_WIDTH` beats.
- Serializer FSM, states IDLE and SEND:
  - IDLE + output command → SEND; load the word and set beat counter = 0.
  - SEND + handshake (`out_valid & out_ready`) → shift right by OUT_WIDTH and increment the counter.
  - Handshake on beat `BEATS-1` → IDLE, unless a new output command arrives in the same cycle; that command is accepted back-to-back and the FSM stays in SEND.
  - Output command in SEND that is not on a final handshake → command ignored and `out_drop` pulses. Store and mask fields of that opcode still execute.
- Signal definitions:
  - `out_valid = (state==SEND)`.
  - `out_last = (state==SEND) & (cnt==BEATS-1)`.
  - `out_data = shreg[OUT_WIDTH-1:0]`.
- Arithmetic: the beat counter is `$clog2(BEATS)` bits wide (minimum 1); global stores truncate to BIT_WIDTH.

## Timing
- Reset values:
  - `mask` = all ones.
  - Globals = 0.
  - State IDLE.
  - `out_valid`=0, `out_last`=0, `out_drop`=0, `out_data`=0.
- Reset asserted mid-word aborts the word; no `out_last` is produced.
- Store and mask updates are visible on the cycle after the accepting edge. `core_execute` reflects the new mask from that cycle onward.
- Output latency: command accepted at edge T gives `out_valid=1` from T+1. With `out_ready` held at 1, the last beat appears at T+BEATS.
- `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- `out_drop` is high for exactly the cycle after the rejecting edge.

## Configuration
- `CORE_ARRAY_REDUCE_EN` defined:
  - A store with `opcode[3]=1` writes the modulo-2^BIT_WIDTH sum of the low BIT_WIDTH bits of every enabled core's accumulator.
  - Zero mask gives a write of 0.
  - `opcode[3]=0` keeps lowest-index store behaviour.
- Undefined: `opcode[3]` is ignored; no adder tree is generated.

## Structure
- Shared package `core_array_pkg` holds:
  - Opcode field constants: MISC class `2'b11`, bit positions 7/4/3, field `[6:5]` with encodings NOP/SEL/ALL/NONE, global index `[12:9]`.
  - The serializer state enum (IDLE, SEND).
- One sub-module, `out_serializer`: the shift register, beat counter, FSM and handshake, parametrised by BIT_WIDTH and OUT_WIDTH.
- Decode, mask, globals and priority/reduce selection stay in the top.

## Test plan
- Reset, then opcode `16'hC040` (select all), then store to g3 with accu0=`8'h5A`, accu1=`8'h11` → `globals_out` slice 3 = `8'h5A`; `core_execute=4'b1111` on execute.
- Select core 2 (`opcode[6:5]=01`, sel=2) → `core_execute=4'b0100`. Disable-all (`11`) → `4'b0000`.
- OUT_WIDTH=2, output core 1 with accu=`8'hB4`, `out_ready=1` → beats 0,1,3,2 on cycles T+1..T+4; `out_last` only at T+4.
- `out_ready` toggled 1,0,0,1… → each beat held stable while stalled; total word intact. A second output command mid-word → `out_drop` pulse; stream unaffected.
- Output command coincident with the final-beat handshake → next word starts at the following cycle with no IDLE bubble.
- With `CORE_ARRAY_REDUCE_EN`, mask `4'b1011`, accus `8'hF0`,`8'h20`,`8'hFF`,`8'h01` → store with `opcode[3]=1` writes `8'h11`; `rst_n` pulsed mid-word → `out_valid` drops immediately.
